noc_output_receiver: RTL and testbench



---
 rtl/snn_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 95 +++++++++
 rtl/noc_output_receiver.sv | 169 ++++++++++++++++
 tb/tb_noc_output_receiver.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : snn_pkg
//  Description : Shared NoC packet layout, packet types and result entry type.
//  Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    localparam int c_dest_msb    = 63;
    localparam int c_dest_lsb    = 60;
    localparam int c_src_msb     = 59;
    localparam int c_src_lsb     = 56;
    localparam int c_type_msb    = 55;
    localparam int c_type_lsb    = 54;
    localparam int c_adder_msb   = 53;
    localparam int c_adder_lsb   = 49;
    localparam int c_ts_msb      = 48;
    localparam int c_ts_lsb      = 45;
    localparam int c_payload_msb = 24;
    localparam int c_payload_lsb = 0;

    localparam logic [3:0] c_addr_ejection = 4'b1000;

    typedef enum logic [1:0] {
        PKT_IFMAP  = 2'b00,
        PKT_FILTER = 2'b01,
        PKT_RESULT = 2'b10,
        PKT_DONE   = 2'b11
    } pkt_type_e;

    typedef struct packed {
        logic [4:0]  adder;
        logic [3:0]  timestep;
        logic [24:0] data;
    } result_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with registered count/full/empty and a
//                registered head entry that holds its value when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter type ENTRY_T = logic [7:0],
    parameter int  DEPTH   = 8
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   i_push,
    input  ENTRY_T i_push_data,
    input  logic   i_pop,
    output ENTRY_T o_head,
    output logic   o_valid,
    output logic   o_full
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);

    ENTRY_T             r_mem [DEPTH];
    ENTRY_T             r_head;
    ENTRY_T             w_head_nxt;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_rd_ptr_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_nxt;
    logic               r_full;
    logic               r_empty;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_push = i_push && !r_full;
    assign w_do_pop  = i_pop && !r_empty;

    always_comb begin
        w_rd_ptr_nxt = w_do_pop ? (r_rd_ptr + c_ptr_one) : r_rd_ptr;
        w_count_nxt  = r_count;
        case ({w_do_push, w_do_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
        // The incoming entry becomes head when it lands in an (effectively) empty FIFO,
        // because its memory slot is only written at this same edge.
        w_head_nxt = r_head;
        if (w_count_nxt != '0) begin
            if (r_empty || (r_count == c_cnt_one && w_do_pop)) begin
                w_head_nxt = i_push_data;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
            r_full   <= (w_count_nxt == c_depth);
            r_empty  <= (w_count_nxt == '0);
            r_head   <= w_head_nxt;
        end
    end

    assign o_head  = r_head;
    assign o_valid = !r_empty;
    assign o_full  = r_full;

endmodule
`default_nettype wire

// File: rtl/noc_output_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : noc_output_receiver
//  Description : NoC ejection endpoint: 4-phase receiver, header decode,
//                result FIFO for host readout and timestep completion pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module noc_output_receiver
    import snn_pkg::*;
#(
    parameter logic [3:0] MY_ADDR     = c_addr_ejection,
    parameter int         NUM_ADDERS  = 7,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_in,
    input  logic [63:0] data_in,
    output logic        ack_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_adder,
    output logic [3:0]  out_timestep,
    output logic [24:0] out_data,
    output logic        timestep_done,
    output logic        done_seen,
    output logic        err_flag
);

    localparam int c_cnt_w = $clog2(NUM_ADDERS + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(NUM_ADDERS - 1);
    localparam logic [4:0]         c_num_add  = 5'(NUM_ADDERS);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_WAIT_LO = 1'b1
    } state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   w_req_s;
    logic                   w_capture;
    logic [c_cnt_w-1:0]     r_res_cnt;
    logic                   r_ts_done;
    logic                   r_done_seen;
    logic                   r_err;
    logic                   w_fifo_full;
    logic                   w_push;
    logic                   w_drop_err;
    logic                   w_done_pkt;
    result_entry_t          w_push_entry;
    result_entry_t          w_head;

    logic [3:0]  w_dest;
    pkt_type_e   w_type;
    logic [4:0]  w_adder;
    logic [3:0]  w_ts;
    logic [24:0] w_payload;
    logic        w_dest_ok;
    logic        w_unused_bits;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_req_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req_in};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A full FIFO holds the FSM in IDLE so the sender sees no ack (backpressure).
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s && !w_fifo_full) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!w_req_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign ack_out = (r_state == ST_WAIT_LO);

    assign w_dest    = data_in[c_dest_msb:c_dest_lsb];
    assign w_type    = pkt_type_e'(data_in[c_type_msb:c_type_lsb]);
    assign w_adder   = data_in[c_adder_msb:c_adder_lsb];
    assign w_ts      = data_in[c_ts_msb:c_ts_lsb];
    assign w_payload = data_in[c_payload_msb:c_payload_lsb];
    assign w_dest_ok = (w_dest == MY_ADDR);
    assign w_unused_bits = ^{data_in[c_src_msb:c_src_lsb], data_in[44:25]};

    assign w_push     = w_capture && w_dest_ok && (w_type == PKT_RESULT) && (w_adder < c_num_add);
    assign w_done_pkt = w_capture && w_dest_ok && (w_type == PKT_DONE);
    assign w_drop_err = w_capture && (!w_dest_ok
                                      || (w_type == PKT_IFMAP)
                                      || (w_type == PKT_FILTER)
                                      || ((w_type == PKT_RESULT) && (w_adder >= c_num_add)));

    assign w_push_entry = '{adder: w_adder, timestep: w_ts, data: w_payload};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_res_cnt   <= '0;
            r_ts_done   <= 1'b0;
            r_done_seen <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_ts_done <= 1'b0;
            if (w_push) begin
                if (r_res_cnt == c_cnt_last) begin
                    r_res_cnt <= '0;
                    r_ts_done <= 1'b1;
                end else begin
                    r_res_cnt <= r_res_cnt + c_cnt_one;
                end
            end
            if (w_done_pkt) begin
                r_done_seen <= 1'b1;
            end
            if (w_drop_err) begin
                r_err <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .ENTRY_T (result_entry_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_result_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (out_ready),
        .o_head      (w_head),
        .o_valid     (out_valid),
        .o_full      (w_fifo_full)
    );

    assign out_adder     = w_head.adder;
    assign out_timestep  = w_head.timestep;
    assign out_data      = w_head.data;
    assign timestep_done = r_ts_done;
    assign done_seen     = r_done_seen;
    assign err_flag      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_output_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_noc_output_receiver
//  Description : Directed self-checking bench for noc_output_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_output_receiver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_in = 1'b0;
    logic [63:0] data_in = '0;
    logic        ack_out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_adder;
    logic [3:0]  out_timestep;
    logic [24:0] out_data;
    logic        timestep_done;
    logic        done_seen;
    logic        err_flag;

    int n_cmp = 0;
    int n_err = 0;
    int ts_pulses = 0;

    noc_output_receiver dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_in        (req_in),
        .data_in       (data_in),
        .ack_out       (ack_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_adder     (out_adder),
        .out_timestep  (out_timestep),
        .out_data      (out_data),
        .timestep_done (timestep_done),
        .done_seen     (done_seen),
        .err_flag      (err_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (timestep_done) ts_pulses++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mk(input logic [3:0] dest, input logic [1:0] typ,
                                       input logic [4:0] adder, input logic [3:0] ts,
                                       input logic [24:0] pl);
        return {dest, 4'h5, typ, adder, ts, 20'hFFFFF, pl};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; req_in = 1'b0; out_ready = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Full 4-phase transfer; latencies are edges from req change to ack change (-1 on timeout).
    task automatic send_pkt(input logic [63:0] pkt, output int lat_up, output int lat_dn,
                            output logic tsd_at_ack);
        @(negedge clk);
        data_in = pkt; req_in = 1'b1;
        lat_up = 0;
        do begin @(posedge clk); #1; lat_up++; end while (!ack_out && lat_up < 20);
        tsd_at_ack = timestep_done;
        if (!ack_out) lat_up = -1;
        req_in = 1'b0;
        lat_dn = 0;
        do begin @(posedge clk); #1; lat_dn++; end while (ack_out && lat_dn < 20);
        if (ack_out) lat_dn = -1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({ack_out, out_valid, timestep_done, done_seen, err_flag} !== 5'b0) begin
            n_err++; $display("FAIL reset_flags: got %b expected 00000",
                              {ack_out, out_valid, timestep_done, done_seen, err_flag});
        end
        n_cmp++;
        if ({out_adder, out_timestep, out_data} !== 34'h0) begin
            n_err++; $display("FAIL reset_head: got %h expected 0", {out_adder, out_timestep, out_data});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        int up, dn; logic t;
        do_reset();
        send_pkt(mk(4'h8, 2'b10, 5'd3, 4'd2, 25'h1ABCDEF), up, dn, t);
        n_cmp++;
        if (up !== 3) begin n_err++; $display("FAIL single_ack_up: got %0d expected 3", up); end
        n_cmp++;
        if (dn !== 3) begin n_err++; $display("FAIL single_ack_dn: got %0d expected 3", dn); end
        n_cmp++;
        if ({out_valid, out_adder, out_timestep, out_data} !== {1'b1, 5'd3, 4'd2, 25'h1ABCDEF}) begin
            n_err++; $display("FAIL single_head: got %b/%0d/%0d/%h expected 1/3/2/1abcdef",
                              out_valid, out_adder, out_timestep, out_data);
        end
    endtask

    task automatic test_timestep();
        int up, dn, base; logic t;
        do_reset();
        out_ready = 1'b1;
        base = ts_pulses;
        for (int i = 0; i < 14; i++) begin
            send_pkt(mk(4'h8, 2'b10, 5'(i % 7), 4'd3, 25'(i)), up, dn, t);
            n_cmp++;
            if (t !== ((i == 6) || (i == 13))) begin
                n_err++; $display("FAIL ts_pulse_pkt%0d: got %b expected %b", i, t, (i == 6) || (i == 13));
            end
            if (i == 6) begin
                n_cmp++;
                if (ts_pulses - base !== 1) begin
                    n_err++; $display("FAIL ts_pulse_count1: got %0d expected 1", ts_pulses - base);
                end
            end
        end
        n_cmp++;
        if (ts_pulses - base !== 2) begin
            n_err++; $display("FAIL ts_pulse_count2: got %0d expected 2", ts_pulses - base);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL ts_drained: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int up, dn, n; logic t; logic stalled_ack;
        logic [24:0] pl [9];
        do_reset();
        for (int k = 0; k < 9; k++) pl[k] = 25'h100000 + 25'(k);
        for (int k = 0; k < 8; k++) begin
            send_pkt(mk(4'h8, 2'b10, 5'(k % 7), 4'(k), pl[k]), up, dn, t);
            n_cmp++;
            if (up !== 3) begin n_err++; $display("FAIL bp_ack_pkt%0d: got %0d expected 3", k, up); end
        end
        n_cmp++;
        if ({out_valid, out_data} !== {1'b1, pl[0]}) begin
            n_err++; $display("FAIL bp_head0: got %b/%h expected 1/%h", out_valid, out_data, pl[0]);
        end
        @(negedge clk);
        data_in = mk(4'h8, 2'b10, 5'd1, 4'd8, pl[8]); req_in = 1'b1;
        stalled_ack = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (ack_out) stalled_ack = 1'b1; end
        n_cmp++;
        if (stalled_ack !== 1'b0) begin n_err++; $display("FAIL bp_stall: got ack=%b expected 0", stalled_ack); end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        n = 0;
        while (!ack_out && n < 10) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (!(ack_out && n >= 1 && n <= 3)) begin
            n_err++; $display("FAIL bp_release: got ack=%b after %0d edges expected ack within 1..3", ack_out, n);
        end
        req_in = 1'b0;
        n = 0;
        while (ack_out && n < 10) begin @(posedge clk); #1; n++; end
        @(negedge clk);
        for (int k = 1; k < 9; k++) begin
            n_cmp++;
            if ({out_valid, out_adder, out_timestep, out_data} !==
                {1'b1, (k == 8) ? 5'd1 : 5'(k % 7), 4'(k), pl[k]}) begin
                n_err++; $display("FAIL bp_order%0d: got %b/%0d/%0d/%h expected 1/%0d/%0d/%h", k,
                                  out_valid, out_adder, out_timestep, out_data,
                                  (k == 8) ? 1 : k % 7, k, pl[k]);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        n_cmp++;
        if ({out_valid, out_data} !== {1'b0, pl[8]}) begin
            n_err++; $display("FAIL bp_empty_hold: got %b/%h expected 0/%h", out_valid, out_data, pl[8]);
        end
    endtask

    task automatic test_errors();
        int up, dn; logic t;
        logic [63:0] bad [3];
        do_reset();
        bad[0] = mk(4'b0011, 2'b10, 5'd1, 4'd1, 25'h11);
        bad[1] = mk(4'b1000, 2'b01, 5'd1, 4'd1, 25'h22);
        bad[2] = mk(4'b1000, 2'b10, 5'd7, 4'd1, 25'h33);
        n_cmp++;
        if (err_flag !== 1'b0) begin n_err++; $display("FAIL err_initial: got %b expected 0", err_flag); end
        for (int k = 0; k < 3; k++) begin
            send_pkt(bad[k], up, dn, t);
            n_cmp++;
            if ({up == 3, err_flag, out_valid} !== 3'b110) begin
                n_err++; $display("FAIL err_pkt%0d: got lat=%0d err=%b valid=%b expected 3/1/0",
                                  k, up, err_flag, out_valid);
            end
        end
    endtask

    task automatic test_done_reset();
        int up, dn, n; logic t;
        do_reset();
        send_pkt(mk(4'h8, 2'b10, 5'd1, 4'd5, 25'h0AAAAA), up, dn, t);
        send_pkt(mk(4'h8, 2'b11, 5'd0, 4'd0, 25'h0), up, dn, t);
        n_cmp++;
        if ({up == 3, done_seen, err_flag} !== 3'b110) begin
            n_err++; $display("FAIL done_pkt: got lat=%0d done=%b err=%b expected 3/1/0", up, done_seen, err_flag);
        end
        n_cmp++;
        if ({out_valid, out_adder, out_data} !== {1'b1, 5'd1, 25'h0AAAAA}) begin
            n_err++; $display("FAIL done_fifo: got %b/%0d/%h expected 1/1/0aaaaa", out_valid, out_adder, out_data);
        end
        @(negedge clk);
        data_in = mk(4'h8, 2'b10, 5'd2, 4'd5, 25'h0BBBBB); req_in = 1'b1;
        n = 0;
        while (!ack_out && n < 20) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (ack_out !== 1'b1) begin n_err++; $display("FAIL rst_pre_ack: got %b expected 1", ack_out); end
        @(negedge clk);
        reset_n = 1'b0; req_in = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({ack_out, done_seen, out_valid, timestep_done, err_flag} !== 5'b0) begin
            n_err++; $display("FAIL rst_mid: got %b expected 00000",
                              {ack_out, done_seen, out_valid, timestep_done, err_flag});
        end
        n_cmp++;
        if (out_data !== 25'h0) begin n_err++; $display("FAIL rst_head: got %h expected 0", out_data); end
        @(negedge clk); reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({ack_out, out_valid} !== 2'b00) begin
            n_err++; $display("FAIL rst_after: got %b expected 00", {ack_out, out_valid});
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_timestep();
        test_backpressure();
        test_errors();
        test_done_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
